// File: rtl/veri_bellek_hakemi.sv
// Data memory (2**ADRES_W x VERI_W) shared by the core port (0) and the debug/loader port (1).
// Round-robin arbitration, one access per cycle, with an optional bounded exclusive lock for port 1.
module veri_bellek_hakemi #(
  parameter int ADRES_W  = 7,
  parameter int VERI_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [31:0]       req0_addr,
  input  logic [VERI_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [VERI_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [31:0]       req1_addr,
  input  logic [VERI_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [VERI_W-1:0] rsp1_rdata,
  output logic              locked,
  output logic [15:0]       stall0_cnt
);

  localparam int DERIN = 1 << ADRES_W;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCK} durum_t;

  durum_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                relock_ok_q, relock_ok_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [15:0]         stall0_q, stall0_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [VERI_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [VERI_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;

  logic [VERI_W-1:0]   mem_q [DERIN];

  logic [ADRES_W-1:0]  idx0, idx1, widx;
  logic                acc0, acc1, mem_we, at_max;
  logic [VERI_W-1:0]   wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req0_addr[31:ADRES_W+2], req0_addr[1:0],
                              req1_addr[31:ADRES_W+2], req1_addr[1:0]};

  assign idx0   = req0_addr[ADRES_W+1:2];
  assign idx1   = req1_addr[ADRES_W+1:2];
  assign at_max = (lock_cnt_q == CNT_W'(LOCK_MAX));

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ARB) begin
      // On a conflict the port that did not win last time is served.
      req0_ready = req0_valid & (~req1_valid | last_grant_q);
      req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
    end else begin
      req1_ready = req1_valid;
    end
  end

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign mem_we = (acc0 & req0_write) | (acc1 & req1_write);
  assign widx   = acc1 ? idx1 : idx0;
  assign wdata  = acc1 ? req1_wdata : req0_wdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    relock_ok_d  = relock_ok_q;
    lock_cnt_d   = lock_cnt_q;
    if (acc0) last_grant_d = 1'b0;
    if (acc1) last_grant_d = 1'b1;
    case (state_q)
      ARB: begin
        if (acc1) begin
          relock_ok_d = 1'b1;
          if (req1_lock && relock_ok_q) begin
            state_d    = LOCK;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
      default: begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (!req1_lock || at_max) begin
          // Port 0 gets the next conflict so the core is never starved twice in a row.
          state_d      = ARB;
          last_grant_d = 1'b1;
          lock_cnt_d   = '0;
          if (at_max) relock_ok_d = 1'b0;
        end
      end
    endcase

    stall0_d = stall0_q;
    if (req0_valid && !req0_ready && stall0_q != 16'hFFFF) stall0_d = stall0_q + 16'd1;

    rsp0_valid_d = acc0 & ~req0_write;
    rsp1_valid_d = acc1 & ~req1_write;
    rsp0_rdata_d = rsp0_valid_d ? mem_q[idx0] : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? mem_q[idx1] : rsp1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      relock_ok_q  <= 1'b1;
      lock_cnt_q   <= '0;
      stall0_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      relock_ok_q  <= relock_ok_d;
      lock_cnt_q   <= lock_cnt_d;
      stall0_q     <= stall0_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // Storage is not reset; a write accepted alongside rst still lands.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= wdata;
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign locked     = (state_q == LOCK);
  assign stall0_cnt = stall0_q;

endmodule
